// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/execute controller for the 16-bit processor.
// Owns the program counter, addresses the combinational instruction ROM,
// latches each word into the instruction register and hands it to the
// datapath until the datapath reports completion.
//
// Handshake: while ir_valid=1 the word in ir is stable and awaiting
// execution; the datapath completes it by holding ex_done=1 at a rising edge,
// which is the only edge at which branch_en/branch_target are sampled.
// ex_done, branch_en and branch_target are ignored whenever ir_valid=0.
module instr_sequencer #(
    parameter int         ADDR_W  = 3,
    parameter int         INSTR_W = 16,
    parameter logic [3:0] HALT_OP = 4'h0,
    parameter bit         WRAP_EN = 1'b1,
    parameter int         CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic [INSTR_W-1:0] ir,
    output logic               ir_valid,
    input  logic               ex_done,
    input  logic               branch_en,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               halted,
    output logic [CNT_W-1:0]   retired,
    output logic [1:0]         state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_ir;
    logic [CNT_W-1:0]   r_retired;
    logic               r_ir_valid;
    logic               r_busy;
    logic               r_halted;

    logic [3:0]         w_opcode;
    logic [ADDR_W-1:0]  w_pc_inc;
    logic [CNT_W-1:0]   w_retired_inc;
    logic               w_end_halt;

    // Opcode of the word currently on the ROM bus, next sequential pc,
    // saturating retire count and the no-wrap end-of-program condition.
    assign w_opcode      = rom_data[INSTR_W-1 -: 4];
    assign w_pc_inc      = r_pc + ADDR_W'(1);
    assign w_retired_inc = (r_retired == '1) ? r_retired : r_retired + CNT_W'(1);
    assign w_end_halt    = !WRAP_EN && (r_pc == LAST_ADDR) && !branch_en;

    // Sequencer FSM; status flags are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_ir       <= '0;
            r_retired  <= '0;
            r_ir_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        r_state    <= S_FETCH;
                        r_pc       <= '0;
                        r_retired  <= '0;
                        r_busy     <= 1'b1;
                        r_halted   <= 1'b0;
                        r_ir_valid <= 1'b0;
                    end
                end
                S_FETCH: begin
                    r_ir <= rom_data;
                    if (w_opcode == HALT_OP) begin
                        // Halt word is latched but never executed or counted.
                        r_state  <= S_HALT;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                    end else begin
                        r_state    <= S_EXEC;
                        r_ir_valid <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (ex_done) begin
                        r_retired  <= w_retired_inc;
                        r_ir_valid <= 1'b0;
                        if (w_end_halt) begin
                            // Ran off the end without wrap: pc stays on last address.
                            r_state  <= S_HALT;
                            r_busy   <= 1'b0;
                            r_halted <= 1'b1;
                        end else begin
                            r_state <= S_FETCH;
                            r_pc    <= branch_en ? branch_target : w_pc_inc;
                        end
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_ir_valid <= 1'b0;
                    r_busy     <= 1'b0;
                    r_halted   <= 1'b0;
                end
            endcase
        end
    end

    // The ROM sees the pc directly so fetch needs no extra cycle.
    assign rom_addr  = r_pc;
    assign pc        = r_pc;
    assign ir        = r_ir;
    assign ir_valid  = r_ir_valid;
    assign busy      = r_busy;
    assign halted    = r_halted;
    assign retired   = r_retired;
    assign state_dbg = r_state;

endmodule
